// File: rtl/bexkat2_intcalc_if.sv
// Request/response bundle between the bexkat2 control sequencer and the integer unit.
interface bexkat2_intcalc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             dbz;

    modport master (output start, func, a, b, input busy, done, result, dbz);
    modport slave  (input start, func, a, b, output busy, done, result, dbz);
endinterface

// File: rtl/bexkat2_intcalc.sv
// bexkat2 iterative integer unit: shift-add multiply, restoring divide, single-cycle unary ops.
// Optional BEXKAT2_INT_EARLYOUT_EN: multiply finishes once the remaining multiplier bits are zero.
module bexkat2_intcalc #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    bexkat2_intcalc_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    typedef enum logic [3:0] {
        F_MUL = 4'd0, F_DIV = 4'd1, F_MOD = 4'd2, F_MULU = 4'd3,
        F_DIVU = 4'd4, F_MODU = 4'd5, F_MULX = 4'd6, F_MULUX = 4'd7,
        F_EXT = 4'd8, F_EXTB = 4'd9, F_COM = 4'd10, F_NEG = 4'd11
    } func_t;

    function automatic logic f_is_mul(input logic [3:0] f);
        return f == F_MUL || f == F_MULU || f == F_MULX || f == F_MULUX;
    endfunction

    function automatic logic f_is_div(input logic [3:0] f);
        return f == F_DIV || f == F_MOD || f == F_DIVU || f == F_MODU;
    endfunction

    function automatic logic f_is_signed(input logic [3:0] f);
        return f == F_MUL || f == F_DIV || f == F_MOD || f == F_MULX;
    endfunction

    state_t               state;
    logic [CNTW-1:0]      cnt;
    logic [3:0]           op;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 neg_res;
    logic                 neg_rem;
    logic [WIDTH-1:0]     stage_res;
    logic                 stage_dbz;

    logic                 in_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH-1:0]     unary_res;
    logic [2*WIDTH-1:0]   mul_acc_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_acc_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic [WIDTH-1:0]     fix_res;

    always_comb begin
        in_signed = f_is_signed(bus.func);
        a_neg     = in_signed & bus.a[WIDTH-1];
        b_neg     = in_signed & bus.b[WIDTH-1];
        a_abs     = a_neg ? ('0 - bus.a) : bus.a;
        b_abs     = b_neg ? ('0 - bus.b) : bus.b;

        unary_res = '0;
        case (bus.func)
            F_EXT:   unary_res = {{(WIDTH-16){bus.a[15]}}, bus.a[15:0]};
            F_EXTB:  unary_res = {{(WIDTH-8){bus.a[7]}}, bus.a[7:0]};
            F_COM:   unary_res = ~bus.a;
            F_NEG:   unary_res = '0 - bus.a;
            default: unary_res = '0;
        endcase
    end

    // acc holds the product for multiply, and {remainder, dividend/quotient} for divide;
    // the divisor reuses the multiplier register.
    always_comb begin
        mul_acc_next = mplier[0] ? (acc + mcand) : acc;
        div_shift    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial    = div_shift - {1'b0, mplier};
        if (div_trial[WIDTH])
            div_acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fix = neg_res ? ('0 - acc) : acc;
        quo_fix  = neg_res ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

        fix_res = '0;
        case (op)
            F_MUL, F_MULU:   fix_res = prod_fix[WIDTH-1:0];
            F_MULX, F_MULUX: fix_res = prod_fix[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU:   fix_res = quo_fix;
            F_MOD, F_MODU:   fix_res = rem_fix;
            default:         fix_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            op         <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            stage_res  <= '0;
            stage_dbz  <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.dbz    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        op       <= bus.func;
                        if (f_is_div(bus.func) && bus.b == '0) begin
                            stage_res <= (bus.func == F_DIV || bus.func == F_DIVU) ? '1 : bus.a;
                            stage_dbz <= 1'b1;
                            state     <= DONE;
                        end else if (f_is_mul(bus.func) || f_is_div(bus.func)) begin
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            mplier  <= b_abs;
                            cnt     <= CNTW'(WIDTH);
                            if (f_is_mul(bus.func)) begin
                                acc   <= '0;
                                mcand <= {{WIDTH{1'b0}}, a_abs};
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, a_abs};
                                mcand <= '0;
                            end
`ifdef BEXKAT2_INT_EARLYOUT_EN
                            if (f_is_mul(bus.func) && b_abs == '0)
                                state <= FIX;
                            else
                                state <= RUN;
`else
                            state <= RUN;
`endif
                        end else begin
                            stage_res <= unary_res;
                            stage_dbz <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNTW'(1);
                    if (f_is_mul(op)) begin
                        acc    <= mul_acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        acc <= div_acc_next;
                    end
`ifdef BEXKAT2_INT_EARLYOUT_EN
                    if (cnt == CNTW'(1) || (f_is_mul(op) && (mplier >> 1) == '0))
                        state <= FIX;
`else
                    if (cnt == CNTW'(1))
                        state <= FIX;
`endif
                end
                FIX: begin
                    stage_res <= fix_res;
                    stage_dbz <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    bus.result <= stage_res;
                    bus.dbz    <= stage_dbz;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bexkat2_intcalc.sv
// Directed self-checking bench for bexkat2_intcalc.
module tb_bexkat2_intcalc;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    bexkat2_intcalc_if #(.WIDTH(32)) bus ();

    bexkat2_intcalc #(.WIDTH(32), .CNTW(6)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] MUL = 4'd0, DIV = 4'd1, MOD = 4'd2, MULU = 4'd3,
                           DIVU = 4'd4, MODU = 4'd5, MULX = 4'd6, MULUX = 4'd7,
                           EXT = 4'd8, EXTB = 4'd9, COM = 4'd10, NEG = 4'd11;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected multiply latency from |multiplier|.
    function automatic int mul_lat(input logic [31:0] babs);
        int h;
`ifdef BEXKAT2_INT_EARLYOUT_EN
        h = -1;
        for (int i = 0; i < 32; i++) if (babs[i]) h = i;
        return (h < 0) ? 2 : h + 3;
`else
        h = 0;
        if (babs[0]) h = 0;
        return 34;
`endif
    endfunction

    task automatic run(input string tag, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ed, input int el);
        int   lat;
        logic busy_mid;
        @(negedge clk);
        bus.start = 1'b1; bus.func = f; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        busy_mid = bus.busy;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(el));
        check({tag, "_res"}, bus.result, er);
        check({tag, "_dbz"}, {31'b0, bus.dbz}, {31'b0, ed});
        if (el > 1) check({tag, "_busy"}, {31'b0, busy_mid}, 32'd1);
    endtask

    initial begin
        int lat;
        int done_cnt;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.func = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst_res",  bus.result, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_dbz",  {31'b0, bus.dbz},  32'd0);
        rst_n = 1'b1;

        run("mulu",   MULU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, mul_lat(32'h0001_0000));
        run("mulux",  MULUX, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, mul_lat(32'h0001_0000));
        run("mul",    MUL,   32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 1'b0, mul_lat(32'd7));
        run("mulx",   MULX,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 1'b0, mul_lat(32'd7));
        run("mulux_max", MULUX, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, mul_lat(32'hFFFF_FFFF));
        run("mulu_zero", MULU, 32'd5, 32'd0, 32'd0, 1'b0, mul_lat(32'd0));
        run("div",    DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 34);
        run("mod",    MOD,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 34);
        run("divu",   DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 34);
        run("modu",   MODU,  32'd100,       32'd7,         32'd2,         1'b0, 34);
        run("div_ovf", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34);
        run("mod_ovf", MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34);
        run("divu_dbz", DIVU, 32'd5,        32'd0,         32'hFFFF_FFFF, 1'b1, 1);
        run("modu_clr", MODU, 32'd5,        32'd3,         32'd2,         1'b0, 34);
        run("mod_dbz",  MOD,  32'd5,        32'd0,         32'd5,         1'b1, 1);
        run("extb",   EXTB,  32'h0000_0080, 32'h0,         32'hFFFF_FF80, 1'b0, 1);
        run("ext",    EXT,   32'h0000_7FFF, 32'h0,         32'h0000_7FFF, 1'b0, 1);
        run("com",    COM,   32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1);
        run("neg",    NEG,   32'd1,         32'h0,         32'hFFFF_FFFF, 1'b0, 1);
        run("neg_min", NEG,  32'h8000_0000, 32'h0,         32'h8000_0000, 1'b0, 1);
        run("undef",  4'd12, 32'h1234_5678, 32'h9,         32'h0,         1'b0, 1);

        // second start mid-operation must not disturb the first multiply
        @(negedge clk);
        bus.start = 1'b1; bus.func = MUL; bus.a = 32'hFFFF_FFFD; bus.b = 32'h0000_1007;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            if (lat == 5) begin
                bus.start = 1'b1; bus.func = MULU; bus.a = 32'h1234_5678; bus.b = 32'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check("ign_lat", 32'(lat), 32'(mul_lat(32'h0000_1007)));
        check("ign_res", bus.result, 32'hFFFF_CFEB);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1; bus.func = DIV; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_res",  bus.result, 32'h0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_nodone", 32'(done_cnt), 32'd0);
        check("abort_idle",   {31'b0, bus.busy}, 32'd0);
        run("after_rst", DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
